// File: rtl/qdr_user_port.sv
// Request/response adapter between a 4-beat user port and a QDRII controller user interface.
// Optional stat_wr_cnt/stat_rd_cnt counters are built when QDR_USER_PORT_STATS_EN is defined.
module qdr_user_port #(
  parameter int unsigned MEM_ADDR_WIDTH  = 19,
  parameter int unsigned MEM_WIDTH       = 36,
  parameter int unsigned MEM_BW_WIDTH    = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                        memclk,
  input  logic                        memreset,
  input  logic                        cal_done,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [MEM_ADDR_WIDTH-1:0]   req_addr,
  input  logic [4*MEM_WIDTH-1:0]      req_data,
  input  logic [4*MEM_BW_WIDTH-1:0]   req_bw_n,
  output logic                        rsp_valid,
  output logic [4*MEM_WIDTH-1:0]      rsp_data,
  output logic                        err_unexpected,
`ifdef QDR_USER_PORT_STATS_EN
  output logic [31:0]                 stat_wr_cnt,
  output logic [31:0]                 stat_rd_cnt,
`endif
  output logic                        user_ad_w_n,
  output logic                        user_d_w_n,
  output logic [MEM_ADDR_WIDTH-1:0]   user_ad_wr,
  output logic [2*MEM_BW_WIDTH-1:0]   user_bw_n,
  output logic [2*MEM_WIDTH-1:0]      user_dw,
  output logic                        user_r_n,
  output logic [MEM_ADDR_WIDTH-1:0]   user_ad_rd,
  input  logic                        user_wr_full,
  input  logic                        user_rd_full,
  input  logic [2*MEM_WIDTH-1:0]      user_qr,
  input  logic                        user_qr_valid
);

  localparam int unsigned DW = 2 * MEM_WIDTH;
  localparam int unsigned BW = 2 * MEM_BW_WIDTH;
  localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

  localparam logic [1:0] StInit = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StWr2  = 2'd2;

  logic [1:0]    state_q;
  logic [3:0]    outstanding_q;
  logic          beat_q;
  logic [DW-1:0] wr_lo_q;
  logic [BW-1:0] bw_lo_q;

  logic wr_acc, rd_acc, first_beat, second_beat, unexpected;

  always_comb begin
    req_ready   = (state_q == StIdle) & cal_done & ~user_wr_full & ~user_rd_full &
                  (outstanding_q < MaxOut);
    wr_acc      = req_valid & req_ready & req_wr;
    rd_acc      = req_valid & req_ready & ~req_wr;
    // A first beat is only legal while a read is in flight.
    first_beat  = user_qr_valid & ~beat_q & (outstanding_q != 4'd0);
    second_beat = user_qr_valid & beat_q;
    unexpected  = user_qr_valid & ~beat_q & (outstanding_q == 4'd0);
  end

  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      state_q <= StInit;
    end else begin
      case (state_q)
        StInit:  if (cal_done) state_q <= StIdle;
        StIdle:  begin
          if (wr_acc)         state_q <= StWr2;
          else if (!cal_done) state_q <= StInit;
        end
        StWr2:   state_q <= cal_done ? StIdle : StInit;
        default: state_q <= StInit;
      endcase
    end
  end

  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      user_ad_w_n <= 1'b1;
      user_d_w_n  <= 1'b1;
      user_r_n    <= 1'b1;
      user_ad_wr  <= '0;
      user_ad_rd  <= '0;
      user_dw     <= '0;
      user_bw_n   <= '1;
      wr_lo_q     <= '0;
      bw_lo_q     <= '1;
    end else begin
      user_ad_w_n <= 1'b1;
      user_d_w_n  <= 1'b1;
      user_r_n    <= 1'b1;
      if (state_q == StWr2) begin
        user_d_w_n <= 1'b0;
        user_dw    <= wr_lo_q;
        user_bw_n  <= bw_lo_q;
      end
      if (wr_acc) begin
        user_ad_w_n <= 1'b0;
        user_d_w_n  <= 1'b0;
        user_ad_wr  <= req_addr;
        user_dw     <= req_data[4*MEM_WIDTH-1 -: DW];
        user_bw_n   <= req_bw_n[4*MEM_BW_WIDTH-1 -: BW];
        wr_lo_q     <= req_data[DW-1:0];
        bw_lo_q     <= req_bw_n[BW-1:0];
      end
      if (rd_acc) begin
        user_r_n   <= 1'b0;
        user_ad_rd <= req_addr;
      end
    end
  end

  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      beat_q         <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      err_unexpected <= 1'b0;
      outstanding_q  <= 4'd0;
    end else begin
      rsp_valid <= second_beat;
      if (first_beat) begin
        rsp_data[4*MEM_WIDTH-1 -: DW] <= user_qr;
        beat_q <= 1'b1;
      end
      if (second_beat) begin
        rsp_data[DW-1:0] <= user_qr;
        beat_q <= 1'b0;
      end
      if (unexpected) err_unexpected <= 1'b1;
      // Simultaneous issue and completion cancel out.
      if (rd_acc && !second_beat && outstanding_q < MaxOut) begin
        outstanding_q <= outstanding_q + 4'd1;
      end else if (second_beat && !rd_acc && outstanding_q != 4'd0) begin
        outstanding_q <= outstanding_q - 4'd1;
      end
    end
  end

`ifdef QDR_USER_PORT_STATS_EN
  always_ff @(posedge memclk or posedge memreset) begin
    if (memreset) begin
      stat_wr_cnt <= 32'd0;
      stat_rd_cnt <= 32'd0;
    end else begin
      if (wr_acc)      stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (second_beat) stat_rd_cnt <= stat_rd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qdr_user_port.sv
// Self-checking bench for qdr_user_port: read responses are checked against a queue of
// expected 144-bit words built from the beats the bench returns.
module tb_qdr_user_port;

  logic         clk = 1'b0;
  logic         memreset, cal_done, req_valid, req_ready, req_wr;
  logic [18:0]  req_addr;
  logic [143:0] req_data;
  logic [15:0]  req_bw_n;
  logic         rsp_valid, err_unexpected;
  logic [143:0] rsp_data;
  logic         user_ad_w_n, user_d_w_n, user_r_n;
  logic [18:0]  user_ad_wr, user_ad_rd;
  logic [7:0]   user_bw_n;
  logic [71:0]  user_dw, user_qr;
  logic         user_wr_full, user_rd_full, user_qr_valid;
`ifdef QDR_USER_PORT_STATS_EN
  logic [31:0]  stat_wr_cnt, stat_rd_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [143:0] exp_q[$];
  logic [143:0] obs_q[$];

  always #5 clk = ~clk;

  qdr_user_port dut (
    .memclk         (clk),
    .memreset       (memreset),
    .cal_done       (cal_done),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_bw_n       (req_bw_n),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .err_unexpected (err_unexpected),
`ifdef QDR_USER_PORT_STATS_EN
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_rd_cnt    (stat_rd_cnt),
`endif
    .user_ad_w_n    (user_ad_w_n),
    .user_d_w_n     (user_d_w_n),
    .user_ad_wr     (user_ad_wr),
    .user_bw_n      (user_bw_n),
    .user_dw        (user_dw),
    .user_r_n       (user_r_n),
    .user_ad_rd     (user_ad_rd),
    .user_wr_full   (user_wr_full),
    .user_rd_full   (user_rd_full),
    .user_qr        (user_qr),
    .user_qr_valid  (user_qr_valid)
  );

  // Responses are collected as they appear; tasks pop and compare.
  always @(posedge clk) if (rsp_valid) obs_q.push_back(rsp_data);

  task automatic test_reset();
    memreset = 1'b1; cal_done = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_data = '0; req_bw_n = '1;
    user_wr_full = 1'b0; user_rd_full = 1'b0; user_qr = '0; user_qr_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, err_unexpected, user_ad_w_n, user_d_w_n, user_r_n} !== 6'b000111) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000111",
               {req_ready, rsp_valid, err_unexpected, user_ad_w_n, user_d_w_n, user_r_n});
    end
    total++;
    if (rsp_data !== '0 || user_ad_wr !== '0 || user_ad_rd !== '0 || user_dw !== '0 ||
        user_bw_n !== 8'hff) begin
      bad++;
      $display("FAIL reset_data got rsp=%h adwr=%h adrd=%h dw=%h bw=%h want zeros bw=ff",
               rsp_data, user_ad_wr, user_ad_rd, user_dw, user_bw_n);
    end
    memreset = 1'b0;
  endtask

  task automatic test_cal();
    for (int c = 0; c <= 13; c++) begin
      cal_done = (c >= 10);
      #1;
      total++;
      if (req_ready !== (c >= 11)) begin
        bad++;
        $display("FAIL cal_ready cycle=%0d got=%b want=%b", c, req_ready, c >= 11);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write();
    logic [143:0] wd [2];
    logic [15:0]  wb [2];
    logic [18:0]  wa [2];
    wd[0] = {36'h111111111, 36'h122222222, 36'h133333333, 36'h144444444};
    wd[1] = {36'hABCDEF012, 36'h3456789AB, 36'hCDEF01234, 36'h56789ABCD};
    wb[0] = 16'h0000; wb[1] = 16'hA53C;
    wa[0] = 19'h00123; wa[1] = 19'h7FEDC;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_wr = 1'b1; req_addr = wa[i]; req_data = wd[i]; req_bw_n = wb[i];
      #1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++; $display("FAIL wr_ready_n got=%b want=1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++;
      if (user_ad_w_n !== 1'b0 || user_d_w_n !== 1'b0 || user_ad_wr !== wa[i] ||
          user_dw !== wd[i][143:72] || user_bw_n !== wb[i][15:8] || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL wr_beat1 got aw=%b dw=%b a=%h d=%h bw=%h rdy=%b want 0 0 %h %h %h 0",
                 user_ad_w_n, user_d_w_n, user_ad_wr, user_dw, user_bw_n, req_ready,
                 wa[i], wd[i][143:72], wb[i][15:8]);
      end
      @(negedge clk);
      total++;
      if (user_ad_w_n !== 1'b1 || user_d_w_n !== 1'b0 || user_dw !== wd[i][71:0] ||
          user_bw_n !== wb[i][7:0]) begin
        bad++;
        $display("FAIL wr_beat2 got aw=%b dw=%b d=%h bw=%h want 1 0 %h %h",
                 user_ad_w_n, user_d_w_n, user_dw, user_bw_n, wd[i][71:0], wb[i][7:0]);
      end
      @(negedge clk);
      total++;
      if (user_d_w_n !== 1'b1 || user_dw !== wd[i][71:0] || req_ready !== 1'b1) begin
        bad++;
        $display("FAIL wr_idle got dw_n=%b d=%h rdy=%b want 1 %h 1",
                 user_d_w_n, user_dw, req_ready, wd[i][71:0]);
      end
    end
  endtask

  task automatic test_reads();
    logic [71:0] b1, b2;
    logic [143:0] got, want;
    req_valid = 1'b1; req_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 19'h00100 + 19'(i);
      #1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++; $display("FAIL rd_ready_%0d got=%b want=1", i, req_ready);
      end
      @(negedge clk);
      total++;
      if (user_r_n !== 1'b0 || user_ad_rd !== 19'h00100 + 19'(i)) begin
        bad++;
        $display("FAIL rd_issue_%0d got r_n=%b a=%h want 0 %h", i, user_r_n, user_ad_rd,
                 19'h00100 + 19'(i));
      end
    end
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL rd_full8 got=%b want=0", req_ready);
    end
    req_valid = 1'b0;
    b1 = 72'hF0E1D2C3B4A5968778; b2 = 72'h0123456789ABCDEF01;
    user_qr_valid = 1'b1; user_qr = b1;
    @(negedge clk);
    user_qr = b2;
    @(negedge clk);
    user_qr_valid = 1'b0;
    exp_q.push_back({b1, b2});
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rsp_cycle got valid=%b rdy=%b want 1 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rsp_after got valid=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    total++;
    if (obs_q.size() != 1) begin
      bad++; $display("FAIL rsp_count got=%0d want=1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL rsp_data got=%h want=%h", got, want);
      end
    end
  endtask

  task automatic test_coincident();
    logic [71:0] c1, c2;
    logic [143:0] got, want;
    c1 = 72'h111122223333444455; c2 = 72'h666677778888999900;
    user_qr_valid = 1'b1; user_qr = c1;
    @(negedge clk);
    user_qr = c2; req_valid = 1'b1; req_wr = 1'b0; req_addr = 19'h00200;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL coin_ready got=%b want=1", req_ready);
    end
    @(negedge clk);
    user_qr_valid = 1'b0; req_valid = 1'b0;
    exp_q.push_back({c1, c2});
    total++;
    if (dut.outstanding_q !== 4'd7 || rsp_valid !== 1'b1 || user_r_n !== 1'b0) begin
      bad++;
      $display("FAIL coin_same got out=%0d valid=%b r_n=%b want 7 1 0",
               dut.outstanding_q, rsp_valid, user_r_n);
    end
    req_valid = 1'b1; req_addr = 19'h00201;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    total++;
    if (dut.outstanding_q !== 4'd8 || req_ready !== 1'b0) begin
      bad++; $display("FAIL coin_full got out=%0d rdy=%b want 8 0", dut.outstanding_q, req_ready);
    end
    // Drain all eight in-flight reads with back-to-back beat pairs.
    user_qr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      c1 = {8'hA0 + 8'(k), 64'h0123456789ABCDEF};
      c2 = {8'hB0 + 8'(k), 64'hFEDCBA9876543210};
      user_qr = c1;
      @(negedge clk);
      user_qr = c2;
      @(negedge clk);
      exp_q.push_back({c1, c2});
    end
    user_qr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs_q.size() != 9 || dut.outstanding_q !== 4'd0) begin
      bad++;
      $display("FAIL drain_count got rsp=%0d out=%0d want 9 0", obs_q.size(), dut.outstanding_q);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++; $display("FAIL drain_data got=%h want=%h", got, want);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_unexpected();
    user_qr_valid = 1'b1; user_qr = 72'hDEADBEEF;
    @(negedge clk);
    user_qr_valid = 1'b0;
    total++;
    if (err_unexpected !== 1'b1) begin
      bad++; $display("FAIL unexp_set got=%b want=1", err_unexpected);
    end
    repeat (4) @(negedge clk);
    total++;
    if (err_unexpected !== 1'b1 || obs_q.size() != 0 || dut.outstanding_q !== 4'd0) begin
      bad++;
      $display("FAIL unexp_sticky got err=%b rsp=%0d out=%0d want 1 0 0",
               err_unexpected, obs_q.size(), dut.outstanding_q);
    end
  endtask

  task automatic test_reset_wr2();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 19'h00300;
    @(negedge clk);
    req_wr = 1'b1; req_addr = 19'h00301; req_data = {4{36'h5A5A5A5A5}}; req_bw_n = 16'h0F0F;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (user_d_w_n !== 1'b0 || dut.outstanding_q !== 4'd1) begin
      bad++; $display("FAIL rst_pre got dw_n=%b out=%0d want 0 1", user_d_w_n, dut.outstanding_q);
    end
    memreset = 1'b1;
    #1;
    total++;
    if (user_d_w_n !== 1'b1 || user_ad_w_n !== 1'b1 || dut.outstanding_q !== 4'd0 ||
        err_unexpected !== 1'b0 || user_dw !== '0) begin
      bad++;
      $display("FAIL rst_async got dw_n=%b aw_n=%b out=%0d err=%b dw=%h want 1 1 0 0 0",
               user_d_w_n, user_ad_w_n, dut.outstanding_q, err_unexpected, user_dw);
    end
    @(negedge clk);
    memreset = 1'b0;
    @(negedge clk);
    total++;
    if (user_d_w_n !== 1'b1 || rsp_valid !== 1'b0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL rst_no_beat2 got dw_n=%b valid=%b rsp=%0d want 1 0 0",
               user_d_w_n, rsp_valid, obs_q.size());
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_recover got=%b want=1", req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_cal();
    test_write();
    test_reads();
    test_coincident();
    test_unexpected();
    test_reset_wr2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
